// File: rtl/ex_issue_ctrl.sv
// EX-stage issue sequencer: accepts decoded ops, stalls on mul/load,
// drives the load request and emits the writeback pulse with unit select.
module ex_issue_ctrl #(
  parameter int MUL_LAT    = 3,
  parameter int LD_TIMEOUT = 255,
  parameter int RD_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [5:0]      op_i,
  input  logic [RD_W-1:0] rd_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  input  logic            mem_ack_i,
  output logic [5:0]      sel_o,
  output logic            wb_valid_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int MW = $clog2(MUL_LAT + 1);
  localparam int LW = $clog2(LD_TIMEOUT + 1);

  localparam logic [MW-1:0] MUL_INIT = MW'(MUL_LAT - 1);
  localparam logic [MW-1:0] MUL_ONE  = MW'(1);
  localparam logic [LW-1:0] LD_MAX   = LW'(LD_TIMEOUT);
  localparam logic [LW-1:0] LD_ONE   = LW'(1);

  localparam logic [5:0] SEL_MUL = 6'b000010;
  localparam logic [5:0] SEL_LD  = 6'b010000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_LD
  } state_t;

  state_t state_q, state_d;

  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [RD_W-1:0] prd_q, prd_d;
  logic [5:0]      sel_q, sel_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            wbv_q, wbv_d;
  logic            req_q, req_d;
  logic            err_q, err_d;

  logic accept;
  logic legal;

  // Ready only when idle, not flushing and out of reset.
  always_comb begin
    issue_ready_o = (state_q == S_IDLE) & ~flush_i & rst;
    accept        = issue_valid_i & issue_ready_o;
    legal         = $onehot(op_i);
  end

  // Next-state and registered-output logic; flush discards any pending work.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    lcnt_d  = lcnt_q;
    prd_d   = prd_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    wbv_d   = 1'b0;
    req_d   = 1'b0;
    err_d   = err_q;
    if (flush_i) begin
      state_d = S_IDLE;
      mcnt_d  = '0;
      lcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!legal) begin
              err_d = 1'b1;
            end else begin
              unique case (1'b1)
                op_i[1]: begin
                  if (MUL_LAT > 1) begin
                    state_d = S_MUL;
                    mcnt_d  = MUL_INIT;
                    prd_d   = rd_i;
                  end else begin
                    wbv_d = 1'b1;
                    sel_d = op_i;
                    rd_d  = rd_i;
                  end
                end
                op_i[4]: begin
                  state_d = S_LD;
                  lcnt_d  = LD_ONE;
                  prd_d   = rd_i;
                  req_d   = 1'b1;
                end
                default: begin
                  wbv_d = 1'b1;
                  sel_d = op_i;
                  rd_d  = rd_i;
                end
              endcase
            end
          end
        end
        S_MUL: begin
          if (mcnt_q == MUL_ONE) begin
            state_d = S_IDLE;
            mcnt_d  = '0;
            wbv_d   = 1'b1;
            sel_d   = SEL_MUL;
            rd_d    = prd_q;
          end else begin
            mcnt_d = mcnt_q - MUL_ONE;
          end
        end
        S_LD: begin
          if (mem_ack_i) begin
            state_d = S_IDLE;
            lcnt_d  = '0;
            wbv_d   = 1'b1;
            sel_d   = SEL_LD;
            rd_d    = prd_q;
          end else if (lcnt_q == LD_MAX) begin
            state_d = S_IDLE;
            lcnt_d  = '0;
            err_d   = 1'b1;
          end else begin
            lcnt_d = lcnt_q + LD_ONE;
            req_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          mcnt_d  = '0;
          lcnt_d  = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mcnt_q  <= '0;
      lcnt_q  <= '0;
      prd_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      wbv_q   <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      lcnt_q  <= lcnt_d;
      prd_q   <= prd_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      wbv_q   <= wbv_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    mem_req_o  = req_q;
    sel_o      = sel_q;
    wb_valid_o = wbv_q;
    wb_rd_o    = rd_q;
    err_o      = err_q;
  end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed scenarios then random traffic,
// checked each cycle against a timestamp-based reference model.
module tb_ex_issue_ctrl;

  localparam int MUL_LAT    = 3;
  localparam int LD_TIMEOUT = 8;
  localparam int RD_W       = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [5:0]      op_i;
  logic [RD_W-1:0] rd_i;
  logic            flush_i;
  logic            mem_req_o;
  logic            mem_ack_i;
  logic [5:0]      sel_o;
  logic            wb_valid_o;
  logic [RD_W-1:0] wb_rd_o;
  logic            busy_o;
  logic            err_o;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl #(
    .MUL_LAT(MUL_LAT),
    .LD_TIMEOUT(LD_TIMEOUT),
    .RD_W(RD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .op_i(op_i),
    .rd_i(rd_i),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o),
    .mem_ack_i(mem_ack_i),
    .sel_o(sel_o),
    .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  // Reference model: one outstanding long op, described by its
  // kind plus the absolute cycle it was accepted / is due.
  int              now = 0;
  bit              live = 0;
  bit              pend = 0;
  bit              pend_ld = 0;
  int              due = 0;
  int              ld_t = 0;
  logic [RD_W-1:0] m_rd = '0;
  bit              e_wbv = 0;
  bit              e_req = 0;
  bit              e_err = 0;
  logic [5:0]      e_sel = '0;
  logic [RD_W-1:0] e_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, now, obs, exp);
    end
  endtask

  task automatic model(input bit v, input logic [5:0] op,
                       input logic [RD_W-1:0] rd, input bit fl,
                       input bit ack, input bit r);
    e_wbv = 0;
    e_req = 0;
    if (!r) begin
      pend  = 0;
      e_sel = '0;
      e_rd  = '0;
      e_err = 0;
      live  = 1;
    end else if (fl) begin
      pend = 0;
    end else if (pend) begin
      if (!pend_ld) begin
        if (now + 1 == due) begin
          e_wbv = 1; e_sel = 6'b000010; e_rd = m_rd; pend = 0;
        end
      end else if (ack) begin
        e_wbv = 1; e_sel = 6'b010000; e_rd = m_rd; pend = 0;
      end else if (now == ld_t + LD_TIMEOUT) begin
        e_err = 1; pend = 0;
      end else begin
        e_req = 1;
      end
    end else if (v) begin
      if ($countones(op) != 1) begin
        e_err = 1;
      end else if (op == 6'b000010 && MUL_LAT > 1) begin
        pend = 1; pend_ld = 0; due = now + MUL_LAT; m_rd = rd;
      end else if (op == 6'b010000) begin
        pend = 1; pend_ld = 1; ld_t = now; m_rd = rd; e_req = 1;
      end else begin
        e_wbv = 1; e_sel = op; e_rd = rd;
      end
    end
  endtask

  task automatic step(input bit v, input logic [5:0] op,
                      input logic [RD_W-1:0] rd, input bit fl,
                      input bit ack, input bit r);
    issue_valid_i = v;
    op_i          = op;
    rd_i          = rd;
    flush_i       = fl;
    mem_ack_i     = ack;
    rst           = r;
    #1;
    chk("ready", 32'(issue_ready_o), 32'(!pend && !fl && r));
    if (live) begin
      chk("busy", 32'(busy_o), 32'(pend));
      chk("wb_valid", 32'(wb_valid_o), 32'(e_wbv));
      chk("sel", 32'(sel_o), 32'(e_sel));
      chk("wb_rd", 32'(wb_rd_o), 32'(e_rd));
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("err", 32'(err_o), 32'(e_err));
    end
    @(posedge clk);
    model(v, op, rd, fl, ack, r);
    now++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 6'd0, '0, 0, 0, 1);
  endtask

  initial begin
    logic [5:0] rop;
    @(negedge clk);
    step(0, 6'd0, '0, 0, 0, 0);
    step(0, 6'd0, '0, 0, 0, 0);
    idle(1);
    // back-to-back single-cycle ops
    step(1, 6'b000001, 5'd5, 0, 0, 1);
    step(1, 6'b000100, 5'd6, 0, 0, 1);
    idle(2);
    // mul then logic in the pulse cycle
    step(1, 6'b000010, 5'd7, 0, 0, 1);
    idle(2);
    step(1, 6'b001000, 5'd3, 0, 0, 1);
    idle(2);
    // load acked at T4
    step(1, 6'b010000, 5'd9, 0, 0, 1);
    idle(3);
    step(0, 6'd0, '0, 0, 1, 1);
    idle(2);
    // load timeout
    step(1, 6'b010000, 5'd10, 0, 0, 1);
    idle(LD_TIMEOUT + 2);
    step(0, 6'd0, '0, 0, 0, 0);
    // load ack in final timeout cycle
    step(1, 6'b010000, 5'd11, 0, 0, 1);
    idle(LD_TIMEOUT - 1);
    step(0, 6'd0, '0, 0, 1, 1);
    idle(2);
    // mul flushed, then valid during flush
    step(1, 6'b000010, 5'd12, 0, 0, 1);
    step(0, 6'd0, '0, 1, 0, 1);
    step(1, 6'b000001, 5'd13, 1, 0, 1);
    idle(3);
    // illegal op, then reset mid-load
    step(1, 6'b000011, 5'd2, 0, 0, 1);
    idle(1);
    step(1, 6'b010000, 5'd4, 0, 0, 1);
    idle(2);
    step(0, 6'd0, '0, 0, 0, 0);
    idle(2);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) != 0) rop = 6'(1 << $urandom_range(5));
      else rop = 6'($urandom);
      step(bit'($urandom_range(3) != 0), rop, RD_W'($urandom),
           bit'($urandom_range(15) == 0), bit'($urandom_range(5) == 0),
           bit'($urandom_range(149) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
